// File: rtl/shift_decoding.sv
// Shift decoder: reorders a 10-byte frame by walking positions start, start+step, ...
// modulo 10, where start and step are derived from an 8-byte key.
module shift_decoding (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:79] data_in,
    input  logic [0:63] final_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:79] data_out,
    output logic        perm_ok,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StKeyprep, StMap, StDone} state_e;

    state_e      state;
    logic [0:79] data_q;
    logic [0:63] key_q;
    logic [7:0]  t_q;
    logic [7:0]  step_q;
    logic [3:0]  j_q;
    logic [9:0]  used_q;

    logic [10:0] key_sum;
    logic [3:0]  start_idx;
    logic [7:0]  key_b0;
    logic [7:0]  s1;
    logic [7:0]  step_v;
    logic [3:0]  idx;

    always_comb begin
        key_sum = '0;
        for (int b = 0; b < 8; b++) begin
            key_sum = key_sum + {3'd0, key_q[8*b +: 8]};
        end
        start_idx = 4'(key_sum % 11'd10);
        key_b0    = key_q[0:7];
        // Even bytes are bumped to odd; multiples of 5 skip ahead so the step is coprime to 10
        // where possible. The 8-bit add wraps, so 0xFF lands on 1.
        s1        = key_b0[0] ? key_b0 : key_b0 + 8'd1;
        step_v    = ((s1 % 8'd5) == 8'd0) ? s1 + 8'd2 : s1;
        idx       = 4'(t_q % 8'd10);
    end

    assign in_ready = (state == StIdle);
    assign busy     = (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            data_out  <= '0;
            perm_ok   <= 1'b0;
            j_q       <= '0;
            used_q    <= '0;
            t_q       <= '0;
            step_q    <= '0;
            data_q    <= '0;
            key_q     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        data_q <= data_in;
                        key_q  <= final_key;
                        state  <= StKeyprep;
                    end
                end
                StKeyprep: begin
                    t_q     <= {4'd0, start_idx};
                    step_q  <= step_v;
                    used_q  <= '0;
                    perm_ok <= 1'b1;
                    j_q     <= '0;
                    state   <= StMap;
                end
                StMap: begin
                    // Collisions only clear perm_ok; the byte is still copied from idx.
                    data_out[8*j_q +: 8] <= data_q[8*idx +: 8];
                    used_q[idx]          <= 1'b1;
                    if (used_q[idx]) begin
                        perm_ok <= 1'b0;
                    end
                    t_q <= t_q + step_q;
                    j_q <= j_q + 4'd1;
                    if (j_q == 4'd9) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_decoding.sv
// Randomized bench for shift_decoding: a frame-level reference model predicts every output each
// cycle; directed frames pin the model and the DUT to hand-computed decodes.
module tb_shift_decoding;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [0:79] data_in = '0;
    logic [0:63] final_key = '0;
    logic        in_ready;
    logic        out_valid;
    logic [0:79] data_out;
    logic        perm_ok;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    logic cmp_en = 1'b0;

    // Model state: m_age = -1 when idle, else edges since the accepting edge.
    int          m_age = -1;
    logic        m_ov = 1'b0;
    logic [0:79] m_do = '0;
    logic        m_pok = 1'b0;
    logic [0:79] cap_d;
    logic [0:63] cap_k;

    shift_decoding dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .final_key (final_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .perm_ok   (perm_ok),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, required finished)");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output byte j comes from input byte ((start + j*step) mod 256) mod 10.
    task automatic decode(input logic [0:79] d, input logic [0:63] k,
                          output logic [0:79] o, output logic pok);
        int sum, start, r, s1, stp, t, idx;
        bit used [10];
        sum = 0;
        for (int b = 0; b < 8; b++) sum += int'(k[8*b +: 8]);
        start = sum % 10;
        r = int'(k[0 +: 8]);
        s1 = (r % 2 == 0) ? r + 1 : r;
        stp = (s1 % 5 == 0) ? (s1 + 2) % 256 : s1;
        for (int i = 0; i < 10; i++) used[i] = 1'b0;
        pok = 1'b1;
        o = '0;
        for (int j = 0; j < 10; j++) begin
            t = (start + j * stp) % 256;
            idx = t % 10;
            if (used[idx]) pok = 1'b0;
            used[idx] = 1'b1;
            o[8*j +: 8] = d[8*idx +: 8];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_age = -1;
                m_ov  = 1'b0;
                m_do  = '0;
                m_pok = 1'b0;
            end else if (m_age == -1) begin
                if (in_valid) begin
                    m_age = 0;
                    cap_d = data_in;
                    cap_k = final_key;
                end
            end else if (m_ov) begin
                if (out_ready) begin
                    m_ov  = 1'b0;
                    m_age = -1;
                end
            end else begin
                m_age++;
                if (m_age == 11) begin
                    m_ov = 1'b1;
                    decode(cap_d, cap_k, m_do, m_pok);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("in_ready", {79'd0, in_ready}, {79'd0, m_age == -1});
                chk("busy", {79'd0, busy}, {79'd0, m_age != -1});
                chk("out_valid", {79'd0, out_valid}, {79'd0, m_ov});
                if (m_age == -1 || m_ov) begin
                    chk("data_out", data_out, m_do);
                    chk("perm_ok", {79'd0, perm_ok}, {79'd0, m_pok});
                end
            end
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Present a frame and advance through the accepting edge.
    task automatic send(input logic [0:79] d, input logic [0:63] k, input bit keep_valid);
        int n;
        n = 0;
        in_valid  = 1'b1;
        data_in   = d;
        final_key = k;
        while (!in_ready && n < 50) begin
            step_clk();
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 required 1 at %0t", $time);
        end
        step_clk();
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            step_clk();
            n++;
        end
    endtask

    task automatic run_frame(input string nm, input logic [0:79] d, input logic [0:63] k,
                             input logic [0:79] exp_d, input logic exp_p);
        int n;
        send(d, k, 1'b0);
        wait_out(n);
        chk({nm, "_latency"}, 80'(n), 80'd11);
        chk({nm, "_data"}, data_out, exp_d);
        chk({nm, "_perm_ok"}, {79'd0, perm_ok}, {79'd0, exp_p});
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;
    endtask

    localparam logic [0:79] DataId   = 80'h00112233445566778899;
    localparam logic [0:79] DataA    = 80'hA0A1A2A3A4A5A6A7A8A9;
    localparam logic [0:63] KeyZero  = 64'h0;
    localparam logic [0:63] KeyPerm  = 64'h0300000000000000;
    localparam logic [0:63] KeyColl  = 64'h7700000000000000;
    localparam logic [0:63] KeyWrap  = 64'hFF00000000000000;
    localparam logic [0:79] ExpPerm  = 80'hA3A6A9A2A5A8A1A4A7A0;
    localparam logic [0:79] ExpColl  = 80'hA9A8A7A0A9A2A1A4A3A6;
    localparam logic [0:79] ExpWrap  = 80'hA5A6A7A8A9A0A1A2A3A4;

    initial begin
        logic [0:79] o;
        logic        p;
        logic [0:79] hold;
        logic [0:79] rd;
        logic [0:63] rk;
        int          n;
        bit          done;

        // Pin the model against hand-derived decodes.
        decode(DataId, KeyZero, o, p);
        chk("model_identity", o, DataId);
        chk("model_identity_ok", {79'd0, p}, 80'd1);
        decode(DataA, KeyPerm, o, p);
        chk("model_perm", o, ExpPerm);
        decode(DataA, KeyColl, o, p);
        chk("model_coll", o, ExpColl);
        chk("model_coll_ok", {79'd0, p}, 80'd0);
        decode(DataA, KeyWrap, o, p);
        chk("model_wrap", o, ExpWrap);

        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        step_clk();
        rst = 1'b0;

        run_frame("identity", DataId, KeyZero, DataId, 1'b1);
        run_frame("perm", DataA, KeyPerm, ExpPerm, 1'b1);
        run_frame("coll", DataA, KeyColl, ExpColl, 1'b0);
        run_frame("wrap", DataA, KeyWrap, ExpWrap, 1'b1);

        // Backpressure with in_valid held high and changing data.
        send(DataA, KeyPerm, 1'b1);
        wait_out(n);
        hold = data_out;
        for (int i = 0; i < 20; i++) begin
            data_in   = {$urandom, $urandom, 16'($urandom)};
            final_key = {$urandom, $urandom};
            step_clk();
            chk("bp_hold", data_out, hold);
            chk("bp_in_ready", {79'd0, in_ready}, 80'd0);
        end
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;
        data_in   = DataA;
        final_key = KeyColl;
        step_clk();
        in_valid = 1'b0;
        chk("bp_next_accept", {79'd0, busy}, 80'd1);
        wait_out(n);
        chk("bp_second_data", data_out, ExpColl);
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;

        // Reset while MAP is processing j = 4.
        send(DataId, KeyPerm, 1'b0);
        repeat (5) step_clk();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        chk("rst_data_out", data_out, 80'd0);
        chk("rst_in_ready", {79'd0, in_ready}, 80'd1);
        chk("rst_out_valid", {79'd0, out_valid}, 80'd0);
        run_frame("post_rst", DataA, KeyPerm, ExpPerm, 1'b1);

        // Random frames with idle gaps, junk on in_valid while busy, random out_ready.
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) step_clk();
            rd = {$urandom, $urandom, 16'($urandom)};
            rk = {$urandom, $urandom};
            if (f % 8 == 3) rk[0:7] = 8'hFF;
            if (f % 8 == 5) rk[0:7] = 8'h04;
            send(rd, rk, 1'b0);
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                out_ready = ($urandom_range(0, 2) == 0);
                in_valid  = $urandom_range(0, 1) == 1;
                data_in   = {$urandom, $urandom, 16'($urandom)};
                final_key = {$urandom, $urandom};
                step_clk();
                if (m_age == -1) done = 1'b1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            if (!done) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rand_timeout: got frame pending required completed at %0t", $time);
            end
        end

        repeat (3) step_clk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
